vita49_unpack_seq: RTL and testbench

Run controller for the VITA-49 unpacker. It takes processor-level commands and sequences the unpacker's control word through reset, start, run, and done/error. It captures the unpacker's error flags and runs an inactivity watchdog. It can re-arm the unpacker automatically for a programmed number of runs, and it raises a one-cycle interrupt at the end of a run sequence or on an error.

---
 rtl/vita49_unpack_seq.sv | 151 +++++++++++++++
 tb/tb_vita49_unpack_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vita49_unpack_seq.sv
// vita49_unpack_seq: run sequencer for the VITA-49 unpacker.
// Drives reset/start, latches error flags, runs a watchdog, auto re-arms, and pulses irq.
module vita49_unpack_seq #(
  parameter int RST_PULSE_CYCLES = 4
) (
  input  logic        AXIS_ACLK,
  input  logic        AXIS_ARESETN,
  input  logic [31:0] sw_ctrl,
  input  logic [31:0] sw_words,
  input  logic [15:0] sw_runs,
  input  logic [31:0] sw_timeout,
  input  logic [31:0] unp_status,
  input  logic        s_xfr_mon,
  output logic [31:0] unp_ctrl,
  output logic [31:0] unp_words,
  output logic [31:0] seq_status,
  output logic [15:0] run_cnt,
  output logic [15:0] err_cnt,
  output logic        irq
);
  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_RESET = 4'd1,
    S_ARM   = 4'd2,
    S_RUN   = 4'd3,
    S_DONE  = 4'd4,
    S_ERR   = 4'd5,
    S_HALT  = 4'd6,
    S_ABORT = 4'd7
  } state_t;
  state_t state_q, state_d;
  logic        go_q;
  logic [31:0] words_q, words_d, wdog_q, wdog_d;
  logic [15:0] runs_q, runs_d, run_cnt_q, run_cnt_d, err_cnt_q, err_cnt_d;
  logic [10:0] err_q, err_d;
  logic [7:0]  pulse_q, pulse_d;
  logic        tmo_q, tmo_d, last_ok_q, last_ok_d, irq_q, irq_d;
  logic        go_ok, abort, rearm, halt_oe, pulse_end, wd_hit, more, busy, unused_bits;
  assign go_ok     = sw_ctrl[0] & ~go_q & ~sw_ctrl[2];
  assign abort     = sw_ctrl[1];
  assign rearm     = sw_ctrl[3];
  assign halt_oe   = sw_ctrl[4];
  assign pulse_end = pulse_q == 8'(RST_PULSE_CYCLES - 1);
  assign wd_hit    = (sw_timeout != 32'd0) && (wdog_q == sw_timeout);
  // runs_q == 0 means the sequence is unlimited
  assign more      = (runs_q == 16'd0) || (runs_q > 16'd1);
  assign busy      = (state_q == S_RESET) || (state_q == S_ARM) || (state_q == S_RUN) || (state_q == S_ABORT);
  assign unused_bits = &{1'b0, sw_ctrl[31:5], unp_status[31:12]};
  always_comb begin
    state_d   = state_q;
    words_d   = words_q;
    runs_d    = runs_q;
    run_cnt_d = run_cnt_q;
    err_cnt_d = err_cnt_q;
    err_d     = err_q;
    tmo_d     = tmo_q;
    last_ok_d = last_ok_q;
    irq_d     = 1'b0;
    case (state_q)
      S_IDLE: if (go_ok) begin
        words_d   = sw_words;
        runs_d    = sw_runs;
        run_cnt_d = '0;
        err_cnt_d = '0;
        err_d     = '0;
        tmo_d     = 1'b0;
        last_ok_d = 1'b0;
        state_d   = S_RESET;
      end
      S_RESET: state_d = abort ? S_ABORT : pulse_end ? S_ARM : S_RESET;
      S_ARM: if (abort) state_d = S_ABORT;
      else if (wd_hit) begin
        tmo_d   = 1'b1;
        err_d   = '0;
        state_d = S_ERR;
      end else if (unp_status[11:0] == 12'd0) state_d = S_RUN;
      S_RUN: if (abort) state_d = S_ABORT;
      else if (|unp_status[11:1]) begin
        err_d   = unp_status[11:1];
        tmo_d   = 1'b0;
        state_d = S_ERR;
      end else if (unp_status[0]) state_d = S_DONE;
      else if (wd_hit) begin
        tmo_d   = 1'b1;
        err_d   = '0;
        state_d = S_ERR;
      end
      S_DONE: if (abort) state_d = S_ABORT;
      else begin
        run_cnt_d = run_cnt_q + 16'd1;
        last_ok_d = 1'b1;
        if (rearm && more) begin
          runs_d  = (runs_q == 16'd0) ? runs_q : runs_q - 16'd1;
          state_d = S_RESET;
        end else begin
          irq_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ERR: if (abort) state_d = S_ABORT;
      else begin
        err_cnt_d = err_cnt_q + 16'(err_cnt_q != 16'hFFFF);
        last_ok_d = 1'b0;
        irq_d     = 1'b1;
        state_d   = halt_oe ? S_HALT : rearm ? S_RESET : S_IDLE;
      end
      S_HALT:  state_d = abort ? S_IDLE : go_ok ? S_RESET : S_HALT;
      S_ABORT: state_d = pulse_end ? S_IDLE : S_ABORT;
      default: state_d = S_IDLE;
    endcase
  end
  // pulse counter restarts on every state change, so RESET and ABORT each hold for a full pulse
  assign pulse_d = ((state_d == state_q) && (state_q == S_RESET || state_q == S_ABORT)) ? pulse_q + 8'd1 : 8'd0;
  assign wdog_d  = ((state_d == S_ARM && state_q != S_ARM) || s_xfr_mon) ? 32'd0 :
                   ((state_q == S_ARM || state_q == S_RUN) && ~&wdog_q) ? wdog_q + 32'd1 : wdog_q;
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_q   <= S_IDLE;
      go_q      <= 1'b0;
      words_q   <= '0;
      runs_q    <= '0;
      run_cnt_q <= '0;
      err_cnt_q <= '0;
      err_q     <= '0;
      tmo_q     <= 1'b0;
      last_ok_q <= 1'b0;
      irq_q     <= 1'b0;
      pulse_q   <= '0;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      go_q      <= sw_ctrl[0];
      words_q   <= words_d;
      runs_q    <= runs_d;
      run_cnt_q <= run_cnt_d;
      err_cnt_q <= err_cnt_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
      last_ok_q <= last_ok_d;
      irq_q     <= irq_d;
      pulse_q   <= pulse_d;
      wdog_q    <= wdog_d;
    end
  end
  assign unp_ctrl   = {29'd0, sw_ctrl[2], (state_q == S_RESET) || (state_q == S_ABORT), (state_q == S_ARM) || (state_q == S_RUN)};
  assign unp_words  = words_q;
  assign seq_status = {13'd0, err_q, last_ok_q, state_q == S_HALT, tmo_q, busy, state_q};
  assign run_cnt    = run_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign irq        = irq_q;
endmodule

// File: tb/tb_vita49_unpack_seq.sv
// tb_vita49_unpack_seq: directed vectors plus hand sequences for the unpacker run sequencer.
module tb_vita49_unpack_seq;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] sw_ctrl, sw_words, sw_timeout, unp_status, unp_ctrl, unp_words, seq_status;
  logic [15:0] sw_runs, run_cnt, err_cnt;
  logic        s_xfr_mon, irq;
  int          n_vec = 0, n_bad = 0, irq_seen = 0;
  localparam logic [3:0] IDLE = 4'd0, RESET = 4'd1, ARM = 4'd2, RUN = 4'd3, DONE = 4'd4, ERR = 4'd5, HALT = 4'd6, ABORT = 4'd7;
  typedef struct {
    logic        hoe;
    logic [31:0] st;
    logic [31:0] tmo;
    logic [3:0]  e_state;
    logic [10:0] e_err;
    logic [15:0] e_ecnt;
    logic [15:0] e_rcnt;
    logic        e_lok;
    logic        e_tbit;
    int          e_irq;
  } vec_t;
  vec_t vt[8];
  vita49_unpack_seq #(.RST_PULSE_CYCLES(4)) dut (
    .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n), .sw_ctrl(sw_ctrl), .sw_words(sw_words),
    .sw_runs(sw_runs), .sw_timeout(sw_timeout), .unp_status(unp_status), .s_xfr_mon(s_xfr_mon),
    .unp_ctrl(unp_ctrl), .unp_words(unp_words), .seq_status(seq_status), .run_cnt(run_cnt),
    .err_cnt(err_cnt), .irq(irq)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (irq) irq_seen++;
  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, got hang expected finish");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_state(input logic [3:0] s, input int lim, input string name);
    int k = 0;
    while (seq_status[3:0] !== s && k < lim) begin
      @(negedge clk);
      k++;
    end
    if (seq_status[3:0] !== s) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: state got %0d expected %0d (wait expired)", name, seq_status[3:0], s);
    end
  endtask
  task automatic count_rst_pulse(output int k);
    k = 0;
    while (unp_ctrl[1] && k < 20) begin
      k++;
      @(negedge clk);
    end
  endtask
  task automatic watchdog_run(input logic beat, output int k);
    sw_ctrl = 32'h1;
    cyc(1);
    sw_ctrl = 32'h0;
    wait_state(ARM, 10, "wd_arm");
    k = 0;
    while (seq_status[3:0] !== ERR && k < 400) begin
      @(negedge clk);
      k++;
      s_xfr_mon = beat && (k == 99);
    end
    s_xfr_mon = 1'b0;
  endtask
  initial begin
    int k;
    vt[0] = '{1'b0, 32'h001,  32'd0,  IDLE, 11'h000, 16'd0, 16'd1, 1'b1, 1'b0, 1};
    vt[1] = '{1'b1, 32'h101,  32'd0,  HALT, 11'h080, 16'd1, 16'd0, 1'b0, 1'b0, 1};
    vt[2] = '{1'b0, 32'h002,  32'd0,  IDLE, 11'h001, 16'd1, 16'd0, 1'b0, 1'b0, 1};
    vt[3] = '{1'b0, 32'hFFE,  32'd0,  IDLE, 11'h7FF, 16'd1, 16'd0, 1'b0, 1'b0, 1};
    vt[4] = '{1'b0, 32'h000,  32'd20, IDLE, 11'h000, 16'd1, 16'd0, 1'b0, 1'b1, 1};
    vt[5] = '{1'b1, 32'h000,  32'd20, HALT, 11'h000, 16'd1, 16'd0, 1'b0, 1'b1, 1};
    vt[6] = '{1'b0, 32'h801,  32'd0,  IDLE, 11'h400, 16'd1, 16'd0, 1'b0, 1'b0, 1};
    vt[7] = '{1'b0, 32'h1001, 32'd0,  IDLE, 11'h000, 16'd0, 16'd1, 1'b1, 1'b0, 1};
    sw_ctrl = '0; sw_words = '0; sw_runs = '0; sw_timeout = '0; unp_status = '0; s_xfr_mon = 1'b0;
    cyc(2);
    chk("rst_seq_status", seq_status, 32'h0);
    chk("rst_unp_ctrl", unp_ctrl, 32'h0);
    chk("rst_unp_words", unp_words, 32'h0);
    chk("rst_counts", {run_cnt, err_cnt}, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    rst_n = 1'b1;
    cyc(1);
    sw_ctrl = 32'h4;
    #1 chk("passthrough_comb", unp_ctrl, 32'h4);
    sw_ctrl = 32'h5;
    cyc(2);
    chk("go_passthrough_ignored", 32'(seq_status[3:0]), 32'(IDLE));
    sw_ctrl = 32'h0;
    cyc(1);
    // single run; go is held high throughout to show it does not retrigger
    sw_words = 32'd8; sw_runs = 16'd1; irq_seen = 0;
    sw_ctrl = 32'h1;
    @(negedge clk);
    chk("t1_busy", 32'(seq_status[4]), 32'h1);
    count_rst_pulse(k);
    chk("t1_rst_pulse_len", 32'(k), 32'd4);
    chk("t1_arm_start", unp_ctrl, 32'h1);
    chk("t1_words", unp_words, 32'd8);
    wait_state(RUN, 10, "t1_run");
    cyc(40);
    unp_status = 32'h1;
    @(negedge clk);
    chk("t1_done_state", 32'(seq_status[3:0]), 32'(DONE));
    chk("t1_start_released", unp_ctrl, 32'h0);
    unp_status = 32'h0;
    @(negedge clk);
    chk("t1_irq_high", 32'(irq), 32'h1);
    chk("t1_idle", 32'(seq_status[3:0]), 32'(IDLE));
    @(negedge clk);
    chk("t1_irq_low", 32'(irq), 32'h0);
    cyc(3);
    chk("t1_run_cnt", 32'(run_cnt), 32'd1);
    chk("t1_last_ok", 32'(seq_status[7]), 32'h1);
    chk("t1_no_retrigger", 32'(seq_status[3:0]), 32'(IDLE));
    chk("t1_irq_count", 32'(irq_seen), 32'd1);
    sw_ctrl = 32'h0;
    cyc(1);
    for (int i = 0; i < 8; i++) begin
      sw_ctrl = 32'h0; unp_status = 32'h0; sw_timeout = vt[i].tmo;
      cyc(1);
      irq_seen = 0;
      sw_ctrl = {27'd0, vt[i].hoe, 4'b0001};
      cyc(1);
      sw_ctrl[0] = 1'b0;
      wait_state(RUN, 30, $sformatf("v%0d_run", i));
      cyc(5);
      unp_status = vt[i].st;
      cyc(40);
      chk($sformatf("v%0d_state", i), 32'(seq_status[3:0]), 32'(vt[i].e_state));
      chk($sformatf("v%0d_err_latched", i), 32'(seq_status[18:8]), 32'(vt[i].e_err));
      chk($sformatf("v%0d_err_cnt", i), 32'(err_cnt), 32'(vt[i].e_ecnt));
      chk($sformatf("v%0d_run_cnt", i), 32'(run_cnt), 32'(vt[i].e_rcnt));
      chk($sformatf("v%0d_last_ok", i), 32'(seq_status[7]), 32'(vt[i].e_lok));
      chk($sformatf("v%0d_timeout", i), 32'(seq_status[5]), 32'(vt[i].e_tbit));
      chk($sformatf("v%0d_halted", i), 32'(seq_status[6]), 32'(vt[i].e_state == HALT));
      chk($sformatf("v%0d_irq_count", i), 32'(irq_seen), 32'(vt[i].e_irq));
      chk($sformatf("v%0d_unp_ctrl", i), unp_ctrl, 32'h0);
      unp_status = 32'h0;
      if (seq_status[3:0] !== IDLE) begin
        sw_ctrl = 32'h2;
        cyc(1);
        chk($sformatf("v%0d_halt_abort", i), 32'(seq_status[3:0]), 32'(IDLE));
        sw_ctrl = 32'h0;
      end
      cyc(1);
    end
    sw_timeout = 32'd0;
    // auto re-arm for three runs, single irq at the end
    sw_runs = 16'd3; irq_seen = 0;
    sw_ctrl = 32'h9;
    cyc(1);
    sw_ctrl = 32'h8;
    for (int i = 0; i < 3; i++) begin
      wait_state(RUN, 30, $sformatf("rearm%0d_run", i));
      cyc(3);
      unp_status = 32'h1;
      wait_state(DONE, 5, $sformatf("rearm%0d_done", i));
      unp_status = 32'h0;
      @(negedge clk);
      chk($sformatf("rearm%0d_next", i), 32'(seq_status[3:0]), (i < 2) ? 32'(RESET) : 32'(IDLE));
    end
    cyc(5);
    chk("rearm_run_cnt", 32'(run_cnt), 32'd3);
    chk("rearm_irq_count", 32'(irq_seen), 32'd1);
    chk("rearm_idle", 32'(seq_status[3:0]), 32'(IDLE));
    sw_ctrl = 32'h0;
    cyc(1);
    // HALT resume keeps counters
    sw_ctrl = 32'h11;
    cyc(1);
    sw_ctrl = 32'h10;
    wait_state(RUN, 30, "halt_run1");
    unp_status = 32'h4;
    wait_state(HALT, 5, "halt_enter1");
    unp_status = 32'h0;
    sw_ctrl = 32'h11;
    cyc(1);
    sw_ctrl = 32'h10;
    chk("halt_go_reset", 32'(seq_status[3:0]), 32'(RESET));
    chk("halt_go_keeps_err_cnt", 32'(err_cnt), 32'd1);
    wait_state(RUN, 30, "halt_run2");
    unp_status = 32'h8;
    wait_state(HALT, 5, "halt_enter2");
    chk("halt_err_cnt2", 32'(err_cnt), 32'd2);
    chk("halt_err_latched2", 32'(seq_status[18:8]), 32'h004);
    unp_status = 32'h0;
    sw_ctrl = 32'h2;
    cyc(1);
    sw_ctrl = 32'h0;
    cyc(1);
    // watchdog: 100-cycle limit, then a beat at count 99 pushes it out
    sw_timeout = 32'd100;
    watchdog_run(1'b0, k);
    chk("wd_nobeat_cycles", 32'(k), 32'd101);
    cyc(2);
    chk("wd_timeout_bit", 32'(seq_status[5]), 32'h1);
    chk("wd_err_latched", 32'(seq_status[18:8]), 32'h0);
    watchdog_run(1'b1, k);
    chk("wd_beat_cycles", 32'(k), 32'd201);
    cyc(2);
    sw_timeout = 32'd0;
    // abort in RUN, with a go edge while busy
    sw_words = 32'd16; irq_seen = 0;
    sw_ctrl = 32'h1;
    cyc(1);
    sw_ctrl = 32'h0;
    wait_state(RUN, 30, "abort_run");
    sw_words = 32'd99;
    sw_ctrl = 32'h1;
    cyc(2);
    chk("busy_go_state", 32'(seq_status[3:0]), 32'(RUN));
    chk("busy_go_words", unp_words, 32'd16);
    sw_ctrl = 32'h2;
    @(negedge clk);
    chk("abort_state", 32'(seq_status[3:0]), 32'(ABORT));
    chk("abort_busy", 32'(seq_status[4]), 32'h1);
    count_rst_pulse(k);
    chk("abort_rst_pulse_len", 32'(k), 32'd4);
    chk("abort_idle", 32'(seq_status[3:0]), 32'(IDLE));
    cyc(2);
    chk("abort_no_irq", 32'(irq_seen), 32'd0);
    chk("abort_run_cnt", 32'(run_cnt), 32'd0);
    sw_ctrl = 32'h0;
    cyc(1);
    // asynchronous reset mid-run
    sw_words = 32'd5; sw_runs = 16'd0;
    sw_ctrl = 32'h9;
    cyc(1);
    sw_ctrl = 32'h8;
    wait_state(RUN, 30, "arst_run1");
    unp_status = 32'h1;
    wait_state(DONE, 5, "arst_done");
    unp_status = 32'h0;
    wait_state(RUN, 30, "arst_run2");
    chk("arst_pre_run_cnt", 32'(run_cnt), 32'd1);
    sw_ctrl = 32'h0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_seq_status", seq_status, 32'h0);
    chk("arst_unp_ctrl", unp_ctrl, 32'h0);
    chk("arst_unp_words", unp_words, 32'h0);
    chk("arst_counts", {run_cnt, err_cnt}, 32'h0);
    chk("arst_irq", 32'(irq), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);
    sw_words = 32'd7;
    sw_ctrl = 32'h1;
    cyc(1);
    chk("arst_fresh_state", 32'(seq_status[3:0]), 32'(RESET));
    chk("arst_fresh_words", unp_words, 32'd7);
    sw_ctrl = 32'h0;
    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
